// File: rtl/differentiate_mc.sv
// Multi-channel time-multiplexed differentiator: per-channel 4-deep history, 5-point or
// 3-point stencil (x12), 3-stage pipeline, shift + saturate. Define DIFF_ROUND_EN for round-half-up.
module differentiate_mc #(
    parameter int unsigned INPUT_WIDTH  = 12,
    parameter int unsigned OUTPUT_WIDTH = 16,
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned SHIFT        = 0,
    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_ni,
    input  logic                           clken_i,
    input  logic                           dvalid_i,
    input  logic [CH_W-1:0]                ch_i,
    input  logic signed [INPUT_WIDTH-1:0]  x_i,
    input  logic                           mode_i,
    input  logic                           clear_i,
    output logic                           dvalid_o,
    output logic [CH_W-1:0]                ch_o,
    output logic signed [OUTPUT_WIDTH-1:0] dx_o,
    output logic                           sat_o
);
    localparam int unsigned FW     = INPUT_WIDTH + 5;
    localparam int unsigned RW     = (FW + 1 > OUTPUT_WIDTH) ? FW + 1 : OUTPUT_WIDTH;
    localparam int unsigned HIST   = 4;
    localparam int unsigned FILL_W = 3;
    localparam logic signed [RW-1:0] SAT_MAX =
        {{(RW - OUTPUT_WIDTH + 1){1'b0}}, {(OUTPUT_WIDTH - 1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;
`ifdef DIFF_ROUND_EN
    localparam logic signed [RW-1:0] RND = RW'((2 ** SHIFT) / 2);
`endif

    logic signed [INPUT_WIDTH-1:0] hist_q [CHANNELS][HIST];
    logic signed [INPUT_WIDTH-1:0] hist_d [CHANNELS][HIST];
    logic [FILL_W-1:0]             fill_q [CHANNELS];
    logic [FILL_W-1:0]             fill_d [CHANNELS];

    logic                          s1_vld_q, s1_vld_d, s1_mode_q, s1_mode_d;
    logic [CH_W-1:0]               s1_ch_q, s1_ch_d;
    logic signed [INPUT_WIDTH-1:0] s1_x0_q, s1_x0_d, s1_x1_q, s1_x1_d;
    logic signed [INPUT_WIDTH-1:0] s1_x3_q, s1_x3_d, s1_x4_q, s1_x4_d;

    logic                          s2_vld_q, s2_vld_d;
    logic [CH_W-1:0]               s2_ch_q, s2_ch_d;
    logic signed [FW-1:0]          s2_a_q, s2_a_d, s2_b_q, s2_b_d;

    logic                          dvalid_q, dvalid_d, sat_q, sat_d;
    logic [CH_W-1:0]               ch_q, ch_d;
    logic signed [OUTPUT_WIDTH-1:0] dx_q, dx_d;

    logic                          accept;
    logic signed [FW-1:0]          diff13, d_full;
    logic signed [RW-1:0]          r_ext;

    assign accept = dvalid_i && (32'(ch_i) < CHANNELS);

    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        s1_vld_d  = s1_vld_q;
        s1_mode_d = s1_mode_q;
        s1_ch_d   = s1_ch_q;
        s1_x0_d   = s1_x0_q;
        s1_x1_d   = s1_x1_q;
        s1_x3_d   = s1_x3_q;
        s1_x4_d   = s1_x4_q;
        s2_vld_d  = s2_vld_q;
        s2_ch_d   = s2_ch_q;
        s2_a_d    = s2_a_q;
        s2_b_d    = s2_b_q;
        dvalid_d  = dvalid_q;
        ch_d      = ch_q;
        dx_d      = dx_q;
        sat_d     = sat_q;
        diff13    = FW'(s1_x1_q) - FW'(s1_x3_q);
        d_full    = s2_a_q + s2_b_q;
        r_ext     = RW'(d_full);
`ifdef DIFF_ROUND_EN
        r_ext     = r_ext + RND;
`endif
        r_ext     = r_ext >>> SHIFT;

        if (clear_i) begin
            // clear beats everything, including a same-cycle accept
            for (int c = 0; c < CHANNELS; c++) begin
                fill_d[c] = '0;
                for (int k = 0; k < HIST; k++) hist_d[c][k] = '0;
            end
            s1_vld_d = 1'b0;
            s2_vld_d = 1'b0;
            dvalid_d = 1'b0;
        end else if (clken_i) begin
            // stage 1: window capture and history update
            s1_vld_d = accept && (fill_q[ch_i] == FILL_W'(HIST));
            if (accept) begin
                s1_mode_d = mode_i;
                s1_ch_d   = ch_i;
                s1_x0_d   = x_i;
                s1_x1_d   = hist_q[ch_i][0];
                s1_x3_d   = hist_q[ch_i][2];
                s1_x4_d   = hist_q[ch_i][3];
                for (int k = HIST - 1; k > 0; k--) hist_d[ch_i][k] = hist_q[ch_i][k-1];
                hist_d[ch_i][0] = x_i;
                if (fill_q[ch_i] != FILL_W'(HIST)) fill_d[ch_i] = fill_q[ch_i] + FILL_W'(1);
            end

            // stage 2: partial sums (5-point: x4-x0 and 8*(x1-x3); 3-point: 6*(x1-x3))
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_ch_d = s1_ch_q;
                if (s1_mode_q) begin
                    s2_a_d = '0;
                    s2_b_d = (diff13 <<< 2) + (diff13 <<< 1);
                end else begin
                    s2_a_d = FW'(s1_x4_q) - FW'(s1_x0_q);
                    s2_b_d = diff13 <<< 3;
                end
            end

            // stage 3: sum, shift, saturate
            dvalid_d = s2_vld_q;
            if (s2_vld_q) begin
                ch_d = s2_ch_q;
                if (r_ext > SAT_MAX) begin
                    dx_d  = OUTPUT_WIDTH'(SAT_MAX);
                    sat_d = 1'b1;
                end else if (r_ext < SAT_MIN) begin
                    dx_d  = OUTPUT_WIDTH'(SAT_MIN);
                    sat_d = 1'b1;
                end else begin
                    dx_d  = OUTPUT_WIDTH'(r_ext);
                    sat_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < CHANNELS; c++) begin
                fill_q[c] <= '0;
                for (int k = 0; k < HIST; k++) hist_q[c][k] <= '0;
            end
            s1_vld_q  <= 1'b0;
            s1_mode_q <= 1'b0;
            s1_ch_q   <= '0;
            s1_x0_q   <= '0;
            s1_x1_q   <= '0;
            s1_x3_q   <= '0;
            s1_x4_q   <= '0;
            s2_vld_q  <= 1'b0;
            s2_ch_q   <= '0;
            s2_a_q    <= '0;
            s2_b_q    <= '0;
            dvalid_q  <= 1'b0;
            ch_q      <= '0;
            dx_q      <= '0;
            sat_q     <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            s1_vld_q  <= s1_vld_d;
            s1_mode_q <= s1_mode_d;
            s1_ch_q   <= s1_ch_d;
            s1_x0_q   <= s1_x0_d;
            s1_x1_q   <= s1_x1_d;
            s1_x3_q   <= s1_x3_d;
            s1_x4_q   <= s1_x4_d;
            s2_vld_q  <= s2_vld_d;
            s2_ch_q   <= s2_ch_d;
            s2_a_q    <= s2_a_d;
            s2_b_q    <= s2_b_d;
            dvalid_q  <= dvalid_d;
            ch_q      <= ch_d;
            dx_q      <= dx_d;
            sat_q     <= sat_d;
        end
    end

    assign dvalid_o = dvalid_q;
    assign ch_o     = ch_q;
    assign dx_o     = dx_q;
    assign sat_o    = sat_q;
endmodule

// File: doc/differentiate_mc.md
Name: differentiate_mc

Overview:
Multi-channel, time-multiplexed differentiator for the ADC sample path. It replaces the single-channel fixed five-point stencil with per-channel sample history and a selectable stencil (5-point or 3-point central difference, both scaled by 12). It also adds configurable output scaling with saturation, and a tagged output-valid strobe for downstream per-channel consumers.

Parameters:
INPUT_WIDTH, 12, width of signed two's-complement input sample
OUTPUT_WIDTH, 16, width of signed saturated output
CHANNELS, 4, number of interleaved channels (>=1); localparam CH_W = max(1, $clog2(CHANNELS))
SHIFT, 0, arithmetic right shift applied to full-precision result before saturation (0..8)

Ports:
clk  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
clken_i  in  1  clock enable; low stalls the entire block (state and outputs hold)
dvalid_i  in  1  input sample valid; sample accepted when clken_i & dvalid_i
ch_i  in  CH_W  channel index of x_i
x_i  in  INPUT_WIDTH  signed input sample
mode_i  in  1  0 = 5-point stencil, 1 = 3-point central; sampled with each accepted sample
clear_i  in  1  synchronous clear of all histories, fill counters and pipeline valids
dvalid_o  out  1  one-cycle strobe: dx_o/ch_o/sat_o valid
ch_o  out  CH_W  channel tag of dx_o
dx_o  out  OUTPUT_WIDTH  signed derivative x12, shifted and saturated
sat_o  out  1  dx_o was clipped this result

Behaviour:
- Reset (rst_ni low, async): all histories 0, fill counters 0, pipeline valids 0; dvalid_o=0, ch_o=0, dx_o=0, sat_o=0.
- Per channel: 4-deep history h[c][1..4] (h1 = newest previous) and 3-bit fill counter saturating at 4.
- Accept: window x0 = x_i (newest), x1..x4 = h[ch_i][1..4]. History shifts in x_i; fill counter increments.
- Back-to-back samples on the same channel must see the just-written history.
- Window valid only if the fill counter was already 4 at accept, i.e. this is the channel's 5th or later sample. Otherwise history updates but no output is produced. Same rule in both modes.
- ch_i >= CHANNELS: sample ignored; no state change, no output.
- Arithmetic (full width FW = INPUT_WIDTH+5, signed):
  - mode 0: d = x4 - 8*x3 + 8*x1 - x0.
  - mode 1: d = 6*(x1 - x3).
  - Both are centred on x2 and have equal group delay.
  - Then r = d >>> SHIFT (truncation toward -inf).
  - Then clip r to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1]; sat_o=1 iff clipped.
- Pipeline: 3 stages (window capture / partial sums / sum-shift-saturate). dvalid_o asserts exactly 3 clken_i-high edges after accept.
- Throughput: one sample per enabled cycle, any channel order.
- clken_i low: no register changes, including dvalid_o. Outputs hold their values, so a stalled strobe stays high until the next enabled edge.
- clear_i: acts on the next clk edge regardless of clken_i. Zeroes histories, fill counters and all in-flight valids; dvalid_o drops.
  - clear_i with a simultaneous accept: clear wins, sample dropped.
- When dvalid_o=0, dx_o/ch_o/sat_o hold their last values.
- mode_i changes do not flush history; each result uses the mode captured with its sample.

Optional Feature:
DIFF_ROUND_EN:
- Defined: round-half-up before shifting, r = (d + 2^(SHIFT-1)) >>> SHIFT for SHIFT>0. The add is done in FW+1 bits so it never overflows before saturation.
- Undefined: pure truncating shift.
- SHIFT=0: identical in both builds.

Test Plan:
1. CHANNELS=4, SHIFT=0, mode 0, ch0 ramp x=0,1,2,...,9 -> no output for first 4 samples. From the 5th on, dvalid_o 3 enabled cycles after each accept, dx_o=12, ch_o=0. Repeat in mode 1 -> dx_o=12.
2. Interleave ch0 ramp +1 and ch1 ramp -2, alternating every cycle for 12 samples each -> ch_o alternates; ch0 results 12, ch1 results -24; first output per channel after its own 5th sample.
3. OUTPUT_WIDTH=12, mode 0, ch0 samples -2048,-2048,-2048,2047,2047 -> d=28665; dx_o=2047, sat_o=1. Negated sequence -> dx_o=-2048, sat_o=1.
4. ch2 ramp, 5 samples -> 1 output. Then clear_i with simultaneous sample -> no output, sample dropped. Next 4 samples -> no output; 5th -> dx_o=12.
5. clken_i low for 3 cycles between accept and result -> dvalid_o delayed 3 cycles, values held. Deassert rst_ni mid-pipeline -> all outputs 0 immediately; no stale result after release.
6. SHIFT=3, ch0 ramp step 1 -> dx_o=1 without DIFF_ROUND_EN, dx_o=2 with it. ch_i=CHANNELS (non-power-of-two CHANNELS=3) -> ignored, no output.
